sys_req_initiator: RTL

Register-access initiator for the system side of a MAC port's management interface. It accepts single read/write commands from the switch control plane and drives the `sys_req_*` request/data channel that the per-port MAC controller responds to. It serialises write payloads byte-wise, collects byte-wise read responses, and returns one completion per command with a timeout error. One instance sits in the system clock domain per MAC port.

---
 rtl/sys_req_initiator.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sys_req_initiator.sv
// System-side management initiator: one read/write command in, one completion
// out, with byte-serial write data and byte-collected read data on sys_req_*.
module sys_req_initiator #(
    parameter int DATA_BYTES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_sys,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [7:0]              cmd_addr,
    input  logic [8*DATA_BYTES-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    sys_req_valid,
    output logic                    sys_req_wr,
    output logic [7:0]              sys_req_addr,
    input  logic                    sys_req_ack,
    output logic [7:0]              sys_req_data,
    output logic                    sys_req_data_valid,
    input  logic [7:0]              sys_resp_data,
    input  logic                    sys_resp_data_valid
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int IW = $clog2(DATA_BYTES + 1);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BYTES);
    localparam logic [IW-1:0] IDX_FINAL = IW'(DATA_BYTES - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WDATA,
        RDATA,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic [7:0]      addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            req_valid_q, req_valid_d;
    logic [7:0]      req_data_q, req_data_d;
    logic            req_dv_q, req_dv_d;
    logic [7:0]      wbyte;
    logic [DW-1:0]   rmerge;

    // Byte selection is MSB first: index 0 is the top byte of the payload.
    always_comb begin
        wbyte  = '0;
        rmerge = rdata_q;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (idx_q == IW'(i)) begin
                wbyte = wdata_q[8*(DATA_BYTES-1-i) +: 8];
                rmerge[8*(DATA_BYTES-1-i) +: 8] = sys_resp_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        req_valid_d = 1'b0;
        req_data_d  = '0;
        req_dv_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    wr_d        = cmd_wr;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    rdata_d     = '0;
                    idx_d       = '0;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    req_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                req_valid_d = 1'b1;
                if (sys_req_ack) begin
                    req_valid_d = 1'b0;
                    cnt_d       = '0;
                    if (wr_q) begin
                        req_dv_d   = 1'b1;
                        req_data_d = wbyte;
                        idx_d      = idx_q + IW'(1);
                        state_d    = WDATA;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WDATA: begin
                if (idx_q == IDX_LAST) begin
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    req_dv_d   = 1'b1;
                    req_data_d = wbyte;
                    idx_d      = idx_q + IW'(1);
                end
            end
            RDATA: begin
                if (sys_resp_data_valid) begin
                    rdata_d = rmerge;
                    cnt_d   = '0;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_FINAL) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rmerge;
                        state_d     = DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = rdata_q;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_valid_q <= 1'b0;
            req_data_q  <= '0;
            req_dv_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_valid_q <= req_valid_d;
            req_data_q  <= req_data_d;
            req_dv_q    <= req_dv_d;
        end
    end

    assign cmd_ready          = cmd_ready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_err            = rsp_err_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign sys_req_valid      = req_valid_q;
    assign sys_req_wr         = wr_q;
    assign sys_req_addr       = addr_q;
    assign sys_req_data       = req_data_q;
    assign sys_req_data_valid = req_dv_q;

endmodule
